// File: rtl/label_map_packer.sv
// label_map_packer: reads the 32x32 label map (one 8-bit label per pixel) out of
// the label SRAM and re-packs it into a 128-byte, 1-bit-per-pixel foreground mask
// streamed over valid/ready. It also tracks the highest label and the number of
// labelled (nonzero) pixels in the frame.
//
// Per packed byte the block spends 9 FETCH cycles and at least 1 OUT cycle.
// Addresses 0..7 of the byte are issued on bit_cnt 0..7. Read data returns one
// cycle later, so it is captured on bit_cnt 1..8.
module label_map_packer #(
    parameter int PX_AW = 10,
    parameter int PK_AW = 7,
    parameter int DW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DW-1:0]    sram_q,
    output logic [PX_AW-1:0] sram_a,
    output logic             sram_wen,
    output logic [DW-1:0]    pk_data,
    output logic [PK_AW-1:0] pk_addr,
    output logic             pk_valid,
    input  logic             pk_ready,
    output logic [DW-1:0]    max_label,
    output logic [PX_AW:0]   pix_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [PK_AW-1:0]  r_byte_idx;
    logic [3:0]        r_bit_cnt;
    logic [DW-1:0]     r_pack;
    logic [PX_AW-1:0]  r_sram_a;
    logic [DW-1:0]     r_pk_data;
    logic [PK_AW-1:0]  r_pk_addr;
    logic              r_pk_valid;
    logic [DW-1:0]     r_max_label;
    logic [PX_AW:0]    r_pix_cnt;

    logic              w_capture;
    logic              w_fetch_last;
    logic              w_accept;
    logic              w_last_byte;
    logic              w_q_nz;
    logic [2:0]        w_bit_pos;
    logic [2:0]        w_next_bit;
    logic [DW-1:0]     w_pack_next;
    logic              w_busy;
    logic              w_done;

    // Decode the FETCH/OUT events the state machine and datapath both need.
    // A capture happens on every FETCH cycle except the first one, because read
    // data lags its address by one cycle.
    assign w_capture    = (r_state == S_FETCH) && (r_bit_cnt != 4'd0);
    assign w_fetch_last = (r_state == S_FETCH) && (r_bit_cnt == 4'd8);
    assign w_accept     = (r_state == S_OUT) && r_pk_valid && pk_ready;
    assign w_last_byte  = (r_byte_idx == {PK_AW{1'b1}});
    assign w_q_nz       = (sram_q != '0);
    // bit_cnt 1..8 maps to bit 0..7. The 3-bit wrap turns 8 into 7.
    assign w_bit_pos    = r_bit_cnt[2:0] - 3'd1;
    assign w_next_bit   = r_bit_cnt[2:0] + 3'd1;

    // Packed byte including the bit arriving this cycle, so the final byte can be loaded in one step.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_pack_next = r_pack;
        if (w_capture) begin
            w_pack_next[w_bit_pos] = w_q_nz;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_fetch_last) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                if (w_accept) begin
                    w_state_next = w_last_byte ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Frame datapath: byte/bit counters, read addressing, packing, statistics and output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_idx  <= '0;
            r_bit_cnt   <= '0;
            r_pack      <= '0;
            r_sram_a    <= '0;
            r_pk_data   <= '0;
            r_pk_addr   <= '0;
            r_pk_valid  <= 1'b0;
            r_max_label <= '0;
            r_pix_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_byte_idx  <= '0;
                        r_bit_cnt   <= '0;
                        r_pack      <= '0;
                        r_sram_a    <= '0;
                        r_max_label <= '0;
                        r_pix_cnt   <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_capture) begin
                        r_pack <= w_pack_next;
                        if (sram_q > r_max_label) begin
                            r_max_label <= sram_q;
                        end
                        if (w_q_nz) begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                    end
                    // The address register runs one bit ahead, so sram_a shows
                    // {byte_idx, bit_cnt} during each issue cycle. After bit 7 it
                    // holds its value through OUT.
                    if (r_bit_cnt < 4'd7) begin
                        r_sram_a <= {r_byte_idx, w_next_bit};
                    end
                    if (w_fetch_last) begin
                        r_pk_data  <= w_pack_next;
                        r_pk_addr  <= r_byte_idx;
                        r_pk_valid <= 1'b1;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                    end
                end
                S_OUT: begin
                    if (w_accept) begin
                        r_pk_valid <= 1'b0;
                        if (!w_last_byte) begin
                            r_byte_idx <= r_byte_idx + 1'b1;
                            r_bit_cnt  <= '0;
                            r_pack     <= '0;
                            r_sram_a   <= {r_byte_idx + 1'b1, 3'd0};
                        end
                    end
                end
                S_DONE: begin
                    // Results stay on max_label/pix_cnt until the next start.
                end
                default: begin
                end
            endcase
        end
    end

    assign sram_a    = r_sram_a;
    assign sram_wen  = 1'b1;     // read-only master: write enable (active-low) never asserted
    assign pk_data   = r_pk_data;
    assign pk_addr   = r_pk_addr;
    assign pk_valid  = r_pk_valid;
    assign max_label = r_max_label;
    assign pix_cnt   = r_pix_cnt;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule

// File: tb/tb_label_map_packer.sv
// Testbench for label_map_packer: a table of whole-frame scenarios plus a
// hand-written mid-frame reset sequence. Expected values come from a reference
// model that works directly from the label array.
module tb_label_map_packer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  sram_q;
    logic [9:0]  sram_a;
    logic        sram_wen;
    logic [7:0]  pk_data;
    logic [6:0]  pk_addr;
    logic        pk_valid;
    logic        pk_ready;
    logic [7:0]  max_label;
    logic [10:0] pix_cnt;
    logic        busy;
    logic        done;

    label_map_packer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sram_q    (sram_q),
        .sram_a    (sram_a),
        .sram_wen  (sram_wen),
        .pk_data   (pk_data),
        .pk_addr   (pk_addr),
        .pk_valid  (pk_valid),
        .pk_ready  (pk_ready),
        .max_label (max_label),
        .pix_cnt   (pix_cnt),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Label SRAM model: synchronous read, data valid the cycle after the address.
    logic [7:0] mem [1024];
    always @(posedge clk) sram_q <= mem[sram_a];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model results.
    logic [7:0] exp_byte     [128];
    int         exp_cnt_pref [128];
    int         exp_max_pref [128];
    int         exp_cnt_all;
    int         exp_max_all;

    typedef struct {
        int pat;         // 0 zeros, 1 corners, 2 even pixels, 3 random dense, 4 random sparse
        int stall_byte;  // byte index held with pk_ready low (-1 none)
        int stall_len;
        bit dup_start;   // pulse start while busy and in DONE
        int exp_max;     // -1: take from reference model
        int exp_cnt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input int pat);
        for (int p = 0; p < 1024; p++) begin
            case (pat)
                0: mem[p] = 8'd0;
                1: mem[p] = (p == 0) ? 8'd3 : ((p == 1023) ? 8'd255 : 8'd0);
                2: mem[p] = (p % 2 == 0) ? 8'((p % 7) + 1) : 8'd0;
                3: mem[p] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0;
                default: mem[p] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(1, 200)) : 8'd0;
            endcase
        end
    endtask

    // Bitmap byte k, bit i = (label of pixel 8k+i != 0); prefix stats after byte k.
    task automatic build_model();
        int cnt;
        int mx;
        cnt = 0;
        mx  = 0;
        for (int k = 0; k < 128; k++) begin
            logic [7:0] b;
            b = 8'd0;
            for (int i = 0; i < 8; i++) begin
                int v;
                v = int'(mem[8*k + i]);
                if (v != 0) begin
                    b[i] = 1'b1;
                    cnt++;
                end
                if (v > mx) mx = v;
            end
            exp_byte[k]     = b;
            exp_cnt_pref[k] = cnt;
            exp_max_pref[k] = mx;
        end
        exp_cnt_all = cnt;
        exp_max_all = mx;
    endtask

    // One full frame, sampled on the falling edge. Cycle 1 is the first cycle after start is taken.
    task automatic run_frame(input int stall_byte, input int stall_len, input bit dup_start,
                             input int want_max, input int want_cnt);
        int cyc;
        int next_idx;
        int shown_idx;
        int stall_left;
        int done_seen;
        int done_cyc;
        logic [9:0] held_a;
        next_idx   = 0;
        shown_idx  = -1;
        stall_left = 0;
        done_seen  = 0;
        done_cyc   = 0;
        held_a     = '0;
        @(negedge clk);
        start    = 1'b1;
        pk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 3000 && !(done_seen > 0 && cyc > done_cyc + 2)) begin
            if (done) begin
                if (done_seen == 0) begin
                    done_cyc = cyc;
                    check("done_cycle", cyc, 1281 + stall_len);
                    check("bytes_before_done", next_idx, 128);
                    check("max_at_done", max_label, want_max);
                    check("pix_at_done", pix_cnt, want_cnt);
                end
                done_seen++;
            end
            check("busy", busy, (done_cyc == 0) || (cyc <= done_cyc));
            if (cyc % 64 == 0) check("sram_wen", sram_wen, 1);
            if (pk_valid) begin
                if (int'(pk_addr) != shown_idx) begin
                    check("pk_addr", pk_addr, next_idx);
                    check("valid_cycle", cyc,
                          10 + 10*next_idx + ((next_idx > stall_byte) ? stall_len : 0));
                    check("pk_data", pk_data, exp_byte[next_idx]);
                    check("pix_prefix", pix_cnt, exp_cnt_pref[next_idx]);
                    check("max_prefix", max_label, exp_max_pref[next_idx]);
                    check("sram_a_hold", sram_a, 8*next_idx + 7);
                    shown_idx  = int'(pk_addr);
                    held_a     = sram_a;
                    stall_left = (shown_idx == stall_byte) ? stall_len : 0;
                end else begin
                    check("stall_data", pk_data, exp_byte[shown_idx]);
                    check("stall_addr", pk_addr, shown_idx);
                    check("stall_sram_a", sram_a, held_a);
                    check("stall_pix", pix_cnt, exp_cnt_pref[shown_idx]);
                end
                if (stall_left > 0) begin
                    pk_ready = 1'b0;
                    stall_left--;
                end else begin
                    pk_ready = 1'b1;
                    next_idx++;
                end
            end else begin
                // Ready while nothing is offered must have no effect.
                pk_ready = 1'($urandom_range(0, 1));
            end
            start = dup_start && (cyc == 5 || cyc == 10 || cyc == 1281);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done_seen == 0) check("done_timeout", 0, 1);
        check("done_pulses", done_seen, 1);
        check("max_hold", max_label, want_max);
        check("pix_hold", pix_cnt, want_cnt);
        check("idle_busy", busy, 0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{0, -1,  0, 1'b0,   0,   0};
        vecs[1] = '{1, -1,  0, 1'b0, 255,   2};
        vecs[2] = '{2, 10,  5, 1'b0,   7, 512};
        vecs[3] = '{2, -1,  0, 1'b1,   7, 512};
        vecs[4] = '{3,  0,  3, 1'b0,  -1,  -1};
        vecs[5] = '{3, 127, 2, 1'b0,  -1,  -1};
        vecs[6] = '{4, -1,  0, 1'b1,  -1,  -1};

        reset    = 1'b1;
        start    = 1'b0;
        pk_ready = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        check("rst_sram_a", sram_a, 0);
        check("rst_wen", sram_wen, 1);
        check("rst_pk_data", pk_data, 0);
        check("rst_pk_addr", pk_addr, 0);
        check("rst_pk_valid", pk_valid, 0);
        check("rst_max", max_label, 0);
        check("rst_pix", pix_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            fill(vecs[v].pat);
            build_model();
            run_frame(vecs[v].stall_byte, vecs[v].stall_len, vecs[v].dup_start,
                      (vecs[v].exp_max < 0) ? exp_max_all : vecs[v].exp_max,
                      (vecs[v].exp_cnt < 0) ? exp_cnt_all : vecs[v].exp_cnt);
        end

        // Reset while byte 40 is being fetched, then a clean frame from address 0.
        fill(3);
        build_model();
        @(negedge clk);
        start    = 1'b1;
        pk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 405; c++) @(negedge clk);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_sram_a_byte", 32'(sram_a[9:3]), 40);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_sram_a", sram_a, 0);
        check("mid_rst_wen", sram_wen, 1);
        check("mid_rst_pk_data", pk_data, 0);
        check("mid_rst_pk_addr", pk_addr, 0);
        check("mid_rst_pk_valid", pk_valid, 0);
        check("mid_rst_max", max_label, 0);
        check("mid_rst_pix", pix_cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_busy", busy, 0);
        run_frame(-1, 0, 1'b0, exp_max_all, exp_cnt_all);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
